// File: rtl/clk_supervisor.sv
// DCM/PLL supervisor: sequences DCM reset and lock acquisition with bounded retries,
// releases downstream domain resets in a staggered order and drives per-channel clock enables.

module clk_supervisor_ce #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             rst_n_q,
  input  logic             rst_n_d,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);
  logic [DIV_W-1:0] cnt, div_q;

  // Keyed off the next channel reset so the enable drops in the same cycle as the reset.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      cnt   <= '0;
      div_q <= '0;
      ce    <= 1'b0;
    end else if (!rst_n_d) begin
      cnt   <= '0;
      div_q <= div;
      ce    <= 1'b0;
    end else if (!rst_n_q) begin
      cnt   <= '0;
      div_q <= div;
      ce    <= (div <= DIV_W'(1));
    end else if (div_q <= DIV_W'(1)) begin
      cnt   <= '0;
      div_q <= div;
      ce    <= 1'b1;
    end else if (cnt == div_q - DIV_W'(1)) begin
      cnt   <= '0;
      div_q <= div;
      ce    <= 1'b1;
    end else begin
      cnt   <= cnt + DIV_W'(1);
      ce    <= 1'b0;
    end
  end
endmodule

module clk_supervisor #(
  parameter int NUM_CH       = 2,
  parameter int RST_PULSE    = 4,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int STAGGER      = 16,
  parameter int MAX_RETRY    = 7,
  parameter int DIV_W        = 8
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic                    dcm_locked,
  input  logic                    dcm_clkfx_stopped,
  input  logic                    relock_req,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic                    dcm_rst,
  output logic [NUM_CH-1:0]       ch_rst_n,
  output logic [NUM_CH-1:0]       ch_ce,
  output logic                    ready,
  output logic                    fault,
  output logic [3:0]              retry_cnt,
  output logic [7:0]              loss_cnt
);
  localparam int IDX_W = $clog2(NUM_CH + 1);

  typedef enum logic [2:0] {RST_DCM, WAIT_LOCK, RELEASE, RUN, FAULT} state_t;

  state_t            state, state_d;
  logic [15:0]       timer, timer_d;
  logic [15:0]       stag, stag_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [3:0]        retry_d;
  logic [7:0]        loss_d;
  logic [NUM_CH-1:0] ch_rst_n_d;
  logic              lk1, lk2, st1, st2;
  logic              good;

  assign good = lk2 && !st2;

  always_comb begin
    state_d    = state;
    timer_d    = timer;
    stag_d     = stag;
    idx_d      = idx;
    retry_d    = retry_cnt;
    loss_d     = loss_cnt;
    ch_rst_n_d = ch_rst_n;
    unique case (state)
      RST_DCM: begin
        if (relock_req) begin
          timer_d = '0;
        end else if (timer == 16'(RST_PULSE - 1)) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer + 16'd1;
        end
      end
      WAIT_LOCK: begin
        timer_d = timer + 16'd1;
        if (relock_req) begin
          state_d = RST_DCM;
          timer_d = '0;
        end else if (good) begin
          state_d = RELEASE;
          idx_d   = '0;
          stag_d  = '0;
        end else if (timer == 16'(LOCK_TIMEOUT)) begin
          retry_d = retry_cnt + 4'd1;
          timer_d = '0;
          state_d = (retry_d == 4'(MAX_RETRY)) ? FAULT : RST_DCM;
        end
      end
      RELEASE: begin
        if (!good || relock_req) begin
          state_d = RST_DCM;
          timer_d = '0;
        end else if (idx == IDX_W'(NUM_CH)) begin
          state_d = RUN;
          retry_d = '0;
        end else if (stag == 16'(STAGGER - 1)) begin
          stag_d = '0;
          idx_d  = idx + IDX_W'(1);
          for (int i = 0; i < NUM_CH; i++)
            if (IDX_W'(i) == idx) ch_rst_n_d[i] = 1'b1;
        end else begin
          stag_d = stag + 16'd1;
        end
      end
      RUN: begin
        if (!good || relock_req) begin
          state_d = RST_DCM;
          timer_d = '0;
          if (!good && loss_cnt != 8'hFF) loss_d = loss_cnt + 8'd1;
        end
      end
      FAULT: begin
        if (relock_req) begin
          state_d = RST_DCM;
          timer_d = '0;
          retry_d = '0;
        end
      end
      default: state_d = RST_DCM;
    endcase
    if (state_d == RST_DCM || state_d == WAIT_LOCK || state_d == FAULT) ch_rst_n_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state     <= RST_DCM;
      timer     <= '0;
      stag      <= '0;
      idx       <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      ch_rst_n  <= '0;
      dcm_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      lk1       <= 1'b0;
      lk2       <= 1'b0;
      st1       <= 1'b0;
      st2       <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      stag      <= stag_d;
      idx       <= idx_d;
      retry_cnt <= retry_d;
      loss_cnt  <= loss_d;
      ch_rst_n  <= ch_rst_n_d;
      dcm_rst   <= (state_d == RST_DCM) || (state_d == FAULT);
      ready     <= (state_d == RUN);
      fault     <= (state_d == FAULT);
      lk1       <= dcm_locked;
      lk2       <= lk1;
      st1       <= dcm_clkfx_stopped;
      st2       <= st1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ce
    clk_supervisor_ce #(.DIV_W(DIV_W)) u_ce (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .rst_n_q (ch_rst_n[g]),
      .rst_n_d (ch_rst_n_d[g]),
      .div     (ch_div[g*DIV_W +: DIV_W]),
      .ce      (ch_ce[g])
    );
  end
endmodule

// File: tb/tb_clk_supervisor.sv
// Scoreboard bench for clk_supervisor: expectations are queued as stimulus is applied and
// consumed in order as the corresponding DUT behaviour is observed.

module tb_clk_supervisor;
  localparam int NUM_CH = 2, RST_PULSE = 4, LOCK_TIMEOUT = 100, STAGGER = 16;
  localparam int MAX_RETRY = 3, DIV_W = 8;
  // RST_DCM entry to ready: reset pulse, one WAIT_LOCK cycle, staggered releases, one cycle to RUN
  localparam int SEQ = RST_PULSE + 1 + NUM_CH * STAGGER + 1;
  localparam int P   = RST_PULSE + LOCK_TIMEOUT + 1;

  logic                    clk_in = 1'b0, reset_n = 1'b0;
  logic                    dcm_locked = 1'b0, dcm_clkfx_stopped = 1'b0, relock_req = 1'b0;
  logic [NUM_CH*DIV_W-1:0] ch_div = '0;
  logic                    dcm_rst, ready, fault;
  logic [NUM_CH-1:0]       ch_rst_n, ch_ce;
  logic [3:0]              retry_cnt;
  logic [7:0]              loss_cnt;

  clk_supervisor #(
    .NUM_CH(NUM_CH), .RST_PULSE(RST_PULSE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STAGGER(STAGGER), .MAX_RETRY(MAX_RETRY), .DIV_W(DIV_W)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .dcm_locked(dcm_locked),
    .dcm_clkfx_stopped(dcm_clkfx_stopped), .relock_req(relock_req), .ch_div(ch_div),
    .dcm_rst(dcm_rst), .ch_rst_n(ch_rst_n), .ch_ce(ch_ce), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { string tag; int val; } sb_t;
  sb_t sb[$];
  int  vectors = 0, miscompares = 0, cyc = 0;
  int  e0, e1, t, r0, r1, rdy, ce0r, gap, dhi, pd, pr, pf;
  int  pulses[$], rises[$], falls[$], rc_at[$], rc_val[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp_v);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp_v);
    end
  endtask

  task automatic sb_push(string tag, int v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(logic [31:0] got);
    sb_t e;
    if (sb.size() == 0) begin
      $display("FAIL sb_empty: got %0d with nothing expected", got);
      $fatal(1);
    end
    e = sb.pop_front();
    chk(e.tag, got, 32'(e.val));
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_ready(int budget);
    for (int i = 0; i < budget && ready !== 1'b1; i++) step();
  endtask

  task automatic pop_list(input int q[$], int n);
    sb_pop(32'(q.size()));
    for (int i = 0; i < n; i++) sb_pop(i < q.size() ? 32'(q[i]) : 32'hFFFF_FFFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---- reset with lock present from the start, then CE dividers in RUN
    dcm_locked = 1'b1;
    ch_div     = {8'd5, 8'd0};
    e0 = RST_PULSE + 1 + STAGGER;
    e1 = e0 + STAGGER;
    sb_push("rst_dcm_rst", 1); sb_push("rst_ch_rst_n", 0); sb_push("rst_ch_ce", 0);
    sb_push("rst_ready", 0);   sb_push("rst_fault", 0);    sb_push("rst_retry", 0);
    sb_push("rst_loss", 0);
    do_reset();
    sb_pop(32'(dcm_rst)); sb_pop(32'(ch_rst_n)); sb_pop(32'(ch_ce)); sb_pop(32'(ready));
    sb_pop(32'(fault));   sb_pop(32'(retry_cnt)); sb_pop(32'(loss_cnt));

    sb_push("dcm_rst_len", RST_PULSE); sb_push("ch0_rise", e0); sb_push("ch1_rise", e1);
    sb_push("ready_at", e1 + 1);       sb_push("ce0_rise", e0); sb_push("ce0_gap", 0);
    sb_push("ce1_pulses", 6);
    for (int k = 1; k <= 4; k++) sb_push("ce1_at", e1 + 5 * k);
    sb_push("ce1_at", e1 + 23); sb_push("ce1_at", e1 + 26);
    r0 = -1; r1 = -1; rdy = -1; ce0r = -1; gap = 0; dhi = 0;
    while (cyc < e1 + 29) begin
      if (dcm_rst) dhi++;
      if (r0 < 0 && ch_rst_n[0]) r0 = cyc;
      if (r1 < 0 && ch_rst_n[1]) r1 = cyc;
      if (rdy < 0 && ready) rdy = cyc;
      if (ce0r < 0 && ch_ce[0]) ce0r = cyc;
      if (ch_rst_n[0] && !ch_ce[0]) gap++;
      if (ch_ce[1]) pulses.push_back(cyc);
      if (cyc == e1 + 17) ch_div[15:8] = 8'd3;   // mid-period change of channel 1
      step();
    end
    sb_pop(32'(dhi)); sb_pop(32'(r0)); sb_pop(32'(r1)); sb_pop(32'(rdy));
    sb_pop(32'(ce0r)); sb_pop(32'(gap));
    pop_list(pulses, 6);
    sb_push("run_retry", 0);
    sb_pop(32'(retry_cnt));

    // ---- one-cycle lock drop in RUN
    sb_push("loss_ready_hold", 1); sb_push("loss_ready", 0); sb_push("loss_ch_rst_n", 0);
    sb_push("loss_ch_ce", 0);      sb_push("loss_cnt", 1);   sb_push("loss_dcm_rst", 1);
    dcm_locked = 1'b0; step(); dcm_locked = 1'b1; step();
    sb_pop(32'(ready));
    step();
    sb_pop(32'(ready)); sb_pop(32'(ch_rst_n)); sb_pop(32'(ch_ce)); sb_pop(32'(loss_cnt));
    sb_pop(32'(dcm_rst));
    t = cyc;
    sb_push("rerun_ready_at", t + SEQ);
    wait_ready(200);
    sb_pop(32'(cyc));

    // ---- relock_req coincident with lock loss: one restart, one loss counted
    sb_push("coinc_loss", 2); sb_push("coinc_ready", 0);
    dcm_locked = 1'b0; step(); dcm_locked = 1'b1; step();
    relock_req = 1'b1; step(); relock_req = 1'b0;
    sb_pop(32'(loss_cnt)); sb_pop(32'(ready));
    t = cyc;
    sb_push("coinc_ready_at", t + SEQ);
    wait_ready(200);
    sb_pop(32'(cyc));

    // ---- software relock, then CLKFX stop during RELEASE
    sb_push("relock_ready", 0); sb_push("relock_loss", 2);
    relock_req = 1'b1; step(); relock_req = 1'b0;
    sb_pop(32'(ready)); sb_pop(32'(loss_cnt));
    t = cyc;
    sb_push("rel_ch0_at", t + RST_PULSE + 1 + STAGGER);
    for (int i = 0; i < 200 && !ch_rst_n[0]; i++) step();
    sb_pop(32'(cyc));
    step(2);
    sb_push("rel_partial", 1);
    sb_pop(32'(ch_rst_n));
    sb_push("stop_ch_rst_n", 0); sb_push("stop_dcm_rst", 1); sb_push("stop_loss", 2);
    sb_push("stop_ready", 0);
    dcm_clkfx_stopped = 1'b1; step(); dcm_clkfx_stopped = 1'b0; step(2);
    sb_pop(32'(ch_rst_n)); sb_pop(32'(dcm_rst)); sb_pop(32'(loss_cnt)); sb_pop(32'(ready));
    t = cyc;
    sb_push("stop_ready_at", t + SEQ);
    wait_ready(200);
    sb_pop(32'(cyc));

    // ---- repeated lock loss: counter saturates at 255
    for (int n = 1; n <= 300; n++) begin
      wait_ready(200);
      sb_push("sat_loss", (2 + n > 255) ? 255 : 2 + n);
      dcm_locked = 1'b0; step(); dcm_locked = 1'b1; step(3);
      sb_pop(32'(loss_cnt));
    end
    wait_ready(200);
    sb_push("sat_ready", 1);
    sb_pop(32'(ready));

    // ---- no lock: timeouts, retries, FAULT, then relock_req recovery
    dcm_locked = 1'b0;
    sb_push("f_reset_loss", 0);
    do_reset();
    sb_pop(32'(loss_cnt));
    sb_push("f_rise_n", 4); for (int k = 0; k < 4; k++) sb_push("f_rise", k * P);
    sb_push("f_fall_n", 3); for (int k = 0; k < 3; k++) sb_push("f_fall", k * P + RST_PULSE);
    sb_push("f_retry_n", 3); for (int k = 1; k <= 3; k++) sb_push("f_retry_at", k * P);
    sb_push("f_retry_vn", 3); for (int k = 1; k <= 3; k++) sb_push("f_retry_val", k);
    sb_push("f_fault_at", 3 * P);
    pd = 0; pr = 0; pf = -1;
    while (cyc < 3 * P + 20) begin
      if (dcm_rst && pd == 0) rises.push_back(cyc);
      if (!dcm_rst && pd == 1) falls.push_back(cyc);
      pd = int'(dcm_rst);
      if (int'(retry_cnt) != pr) begin
        rc_at.push_back(cyc);
        rc_val.push_back(int'(retry_cnt));
        pr = int'(retry_cnt);
      end
      if (pf < 0 && fault) pf = cyc;
      step();
    end
    pop_list(rises, 4); pop_list(falls, 3); pop_list(rc_at, 3); pop_list(rc_val, 3);
    sb_pop(32'(pf));
    sb_push("fault_hold", 1); sb_push("fault_dcm_rst", 1); sb_push("fault_ch_rst_n", 0);
    sb_pop(32'(fault)); sb_pop(32'(dcm_rst)); sb_pop(32'(ch_rst_n));

    sb_push("rec_fault", 0); sb_push("rec_retry", 0); sb_push("rec_dcm_rst", 1);
    dcm_locked = 1'b1; relock_req = 1'b1; step(); relock_req = 1'b0;
    sb_pop(32'(fault)); sb_pop(32'(retry_cnt)); sb_pop(32'(dcm_rst));
    t = cyc;
    sb_push("rec_ready_at", t + SEQ);
    wait_ready(200);
    sb_pop(32'(cyc));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
